// File: rtl/issue_scheduler_if.sv
// Decode, scoreboard and issue signals of the dual-issue scheduler.
// The master modport is the surrounding pipeline; the slave modport is the scheduler.
interface issue_scheduler_if #(
  parameter int POS_W = 8,
  parameter int ID_W  = 6
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_slot_v;
  logic [1:0][ID_W-1:0]       in_id;
  logic [1:0][4:0]            in_rs;
  logic [1:0][4:0]            in_rt;
  logic [1:0][4:0]            in_rd;
  logic [1:0]                 in_wr;
  logic [1:0][2:0]            in_lat;
  logic [1:0]                 in_mem;
  logic [1:0]                 in_mdu;
  logic [3:0][4:0]            sb_read_addr;
  logic [3:0][POS_W-1:0]      sb_pos;
  logic [1:0]                 sb_write_ena;
  logic [1:0][4:0]            sb_write_addr;
  logic [1:0][POS_W-1:0]      sb_write_pos;
  logic [1:0]                 issue_valid;
  logic [1:0][ID_W-1:0]       issue_id;

  modport master (
    output in_valid, in_slot_v, in_id, in_rs, in_rt, in_rd, in_wr, in_lat, in_mem, in_mdu,
    output sb_pos,
    input  in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_write_pos,
    input  issue_valid, issue_id
  );

  modport slave (
    input  in_valid, in_slot_v, in_id, in_rs, in_rt, in_rd, in_wr, in_lat, in_mem, in_mdu,
    input  sb_pos,
    output in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_write_pos,
    output issue_valid, issue_id
  );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue in-order issue controller: two-entry pair buffer, scoreboard checks, MDU busy FSM.
// Optional macro ISSUE_PERF_CNT_EN adds the perf_dual / perf_hazard event counters.
module issue_scheduler #(
  parameter int POS_W     = 8,
  parameter int FWD_SLACK = 1,
  parameter int MDU_LAT   = 6,
  parameter int ID_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  issue_scheduler_if.slave  bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_dual,
  output logic [31:0]       perf_hazard
`endif
);
  localparam int CNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            wr;
    logic [2:0]      lat;
    logic            mem;
    logic            mdu;
  } entry_t;

  typedef enum logic {IDLE, BUSY} mdu_state_t;

  entry_t     b0_reg, b0_next, b1_reg, b1_next;
  entry_t     in_entry [2];
  entry_t     slot     [2];
  mdu_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [3:0][4:0] rd_addr;
  logic [3:0]      opnd_rdy;
  logic            busy, iss0, iss1, raw, waw, accept, mdu_issue;
  logic [1:0]      iss;

  assign slot[0] = b0_reg;
  assign slot[1] = b1_reg;
  assign rd_addr = {b1_reg.rt, b1_reg.rs, b0_reg.rt, b0_reg.rs};
  assign bus.sb_read_addr = rd_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_opnd
      assign opnd_rdy[gi] = (rd_addr[gi] == 5'd0) || ((bus.sb_pos[gi] >> FWD_SLACK) == '0);
    end
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign in_entry[gi] = '{valid: 1'b1, id: bus.in_id[gi], rs: bus.in_rs[gi],
                              rt: bus.in_rt[gi], rd: bus.in_rd[gi], wr: bus.in_wr[gi],
                              lat: bus.in_lat[gi], mem: bus.in_mem[gi], mdu: bus.in_mdu[gi]};
      assign bus.sb_write_ena[gi]  = iss[gi] && slot[gi].wr && (slot[gi].rd != 5'd0);
      assign bus.sb_write_addr[gi] = slot[gi].rd;
      assign bus.sb_write_pos[gi]  = POS_W'(1) << slot[gi].lat;
      assign bus.issue_id[gi]      = slot[gi].id;
    end
  endgenerate

  assign busy = (state_reg == BUSY);
  assign raw  = b0_reg.wr && (b0_reg.rd != 5'd0) &&
                ((b0_reg.rd == b1_reg.rs) || (b0_reg.rd == b1_reg.rt));
  assign waw  = b0_reg.wr && b1_reg.wr && (b0_reg.rd == b1_reg.rd);

  assign iss0 = b0_reg.valid && opnd_rdy[0] && opnd_rdy[1] &&
                !(b0_reg.mdu && busy) && !stall && !flush;
  assign iss1 = iss0 && b1_reg.valid && opnd_rdy[2] && opnd_rdy[3] && !raw && !waw &&
                !(b0_reg.mem && b1_reg.mem) && !(b0_reg.mdu && b1_reg.mdu) &&
                !(b1_reg.mdu && busy);
  assign iss  = {iss1, iss0};
  assign bus.issue_valid = iss;

  // B1 is never valid without B0 (compaction), so "all valid entries issue" reduces to this.
  assign bus.in_ready = !stall && !flush &&
                        ((!b0_reg.valid && !b1_reg.valid) || (iss0 && (!b1_reg.valid || iss1)));
  assign accept    = bus.in_valid && bus.in_ready;
  assign mdu_issue = (iss0 && b0_reg.mdu) || (iss1 && b1_reg.mdu);

  always_comb begin
    b0_next = b0_reg;
    b1_next = b1_reg;
    if (flush) begin
      b0_next = '0;
      b1_next = '0;
    end else if (!stall) begin
      if (accept) begin
        b0_next = '0;
        b1_next = '0;
        if (bus.in_slot_v[0]) begin
          b0_next = in_entry[0];
          if (bus.in_slot_v[1]) b1_next = in_entry[1];
        end else if (bus.in_slot_v[1]) begin
          b0_next = in_entry[1];
        end
      end else if (iss1) begin
        b0_next = '0;
        b1_next = '0;
      end else if (iss0) begin
        b0_next = b1_reg;
        b1_next = '0;
      end
    end
  end

  // BUSY covers the MDU_LAT-1 cycles after the issuing one, so the next MDU op
  // can issue exactly MDU_LAT non-stalled cycles after the previous one.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (!stall) begin
      case (state_reg)
        IDLE: if (mdu_issue) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(MDU_LAT - 1);
        end
        BUSY: if (cnt_reg <= CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b0_reg    <= '0;
      b1_reg    <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      b0_reg    <= b0_next;
      b1_reg    <= b1_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] dual_reg, hazard_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dual_reg   <= '0;
      hazard_reg <= '0;
    end else begin
      if (iss1) dual_reg <= dual_reg + 32'd1;
      if (!stall && !flush && b0_reg.valid && !iss0) hazard_reg <= hazard_reg + 32'd1;
    end
  end

  assign perf_dual   = dual_reg;
  assign perf_hazard = hazard_reg;
`else
  // Default build carries no event counters.
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: pair issue, hazards, MDU busy timing, stall and flush.
module tb_issue_scheduler;
  localparam int POS_W = 8;
  localparam int ID_W  = 6;

  logic clk = 1'b0;
  logic rst, stall, flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  issue_scheduler_if #(.POS_W(POS_W), .ID_W(ID_W)) bus ();

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_dual, perf_hazard;
`endif

  issue_scheduler #(.POS_W(POS_W), .FWD_SLACK(1), .MDU_LAT(6), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_dual   (perf_dual),
    .perf_hazard (perf_hazard)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.in_valid  = 1'b0;
    bus.in_slot_v = '0;
    bus.in_id     = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.in_wr     = '0;
    bus.in_lat    = '0;
    bus.in_mem    = '0;
    bus.in_mdu    = '0;
    bus.sb_pos    = '0;
    stall         = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [ID_W-1:0] id, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic wr,
                          input logic [2:0] lat, input logic mem, input logic mdu);
    bus.in_slot_v[s] = 1'b1;
    bus.in_id[s]     = id;
    bus.in_rs[s]     = rs;
    bus.in_rt[s]     = rt;
    bus.in_rd[s]     = rd;
    bus.in_wr[s]     = wr;
    bus.in_lat[s]    = lat;
    bus.in_mem[s]    = mem;
    bus.in_mdu[s]    = mdu;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_issue_valid", bus.issue_valid, 0);
    check_eq("rst_sb_write_ena", bus.sb_write_ena, 0);

    // Independent pair issues together.
    bus.in_valid = 1'b1;
    set_slot(0, 6'd1, 5'd2, 5'd3, 5'd1, 1'b1, 3'd1, 1'b0, 1'b0);
    set_slot(1, 6'd2, 5'd5, 5'd6, 5'd4, 1'b1, 3'd3, 1'b0, 1'b0);
    #1 check_eq("t1_accept_ready", bus.in_ready, 1);
    tick(); clear_inputs(); #1;
    check_eq("t1_issue_valid", bus.issue_valid, 2'b11);
    check_eq("t1_issue_id", bus.issue_id, {6'd2, 6'd1});
    check_eq("t1_read_addr", bus.sb_read_addr, {5'd6, 5'd5, 5'd3, 5'd2});
    check_eq("t1_write_ena", bus.sb_write_ena, 2'b11);
    check_eq("t1_write_addr", bus.sb_write_addr, {5'd4, 5'd1});
    check_eq("t1_write_pos", bus.sb_write_pos, {8'h08, 8'h02});
    check_eq("t1_in_ready", bus.in_ready, 1);
    tick();

    // Intra-pair RAW splits the pair over two cycles.
    bus.in_valid = 1'b1;
    set_slot(0, 6'd3, 5'd2, 5'd3, 5'd1, 1'b1, 3'd2, 1'b0, 1'b0);
    set_slot(1, 6'd4, 5'd1, 5'd7, 5'd8, 1'b1, 3'd1, 1'b0, 1'b0);
    tick(); clear_inputs(); #1;
    check_eq("t2_c0_issue_valid", bus.issue_valid, 2'b01);
    check_eq("t2_c0_in_ready", bus.in_ready, 0);
    check_eq("t2_c0_write_ena", bus.sb_write_ena, 2'b01);
    check_eq("t2_c0_write_pos0", bus.sb_write_pos[0], 8'h04);
    tick(); #1;
    check_eq("t2_c1_issue_valid", bus.issue_valid, 2'b01);
    check_eq("t2_c1_issue_id0", bus.issue_id[0], 6'd4);
    check_eq("t2_c1_in_ready", bus.in_ready, 1);
    check_eq("t2_c1_write_addr0", bus.sb_write_addr[0], 5'd8);
    tick();

    // Scoreboard hazard on s0.rs: position shifts 4 -> 2 -> 1.
    bus.in_valid = 1'b1;
    set_slot(0, 6'd5, 5'd9, 5'd10, 5'd11, 1'b1, 3'd1, 1'b0, 1'b0);
    tick(); clear_inputs(); bus.sb_pos[0] = 8'h04; #1;
    check_eq("t3_pos4_issue_valid", bus.issue_valid, 0);
    check_eq("t3_pos4_in_ready", bus.in_ready, 0);
    tick(); bus.sb_pos[0] = 8'h02; #1;
    check_eq("t3_pos2_issue_valid", bus.issue_valid, 0);
    tick(); bus.sb_pos[0] = 8'h01; #1;
    check_eq("t3_pos1_issue_valid", bus.issue_valid, 2'b01);
    check_eq("t3_pos1_write_ena", bus.sb_write_ena, 2'b01);
    tick(); clear_inputs();

    // MDU busy: second div issues 6 cycles after the first.
    bus.in_valid = 1'b1;
    set_slot(0, 6'd6, 5'd2, 5'd3, 5'd0, 1'b0, 3'd1, 1'b0, 1'b1);
    tick(); clear_inputs(); #1;
    check_eq("t4_div_a_issue", bus.issue_valid, 2'b01);
    check_eq("t4_div_a_write_ena", bus.sb_write_ena, 0);
    tick();
    tick();
    bus.in_valid = 1'b1;
    set_slot(0, 6'd7, 5'd2, 5'd3, 5'd0, 1'b0, 3'd1, 1'b0, 1'b1);
    #1 check_eq("t4_div_b_ready", bus.in_ready, 1);
    tick();
    for (int k = 3; k <= 6; k++) begin
      clear_inputs(); #1;
      check_eq($sformatf("t4_wait%0d_issue", k), bus.issue_valid, (k == 6) ? 2'b01 : 2'b00);
      tick();
    end

    // Same again with a 3-cycle stall in between: 9 cycles.
    tick();
    bus.in_valid = 1'b1;
    set_slot(0, 6'd8, 5'd2, 5'd3, 5'd0, 1'b0, 3'd1, 1'b0, 1'b1);
    tick();
    for (int k = 3; k <= 9; k++) begin
      clear_inputs();
      stall = (k >= 3 && k <= 5);
      #1;
      check_eq($sformatf("t4s_wait%0d_issue", k), bus.issue_valid, (k == 9) ? 2'b01 : 2'b00);
      if (stall) check_eq($sformatf("t4s_stall%0d_ready", k), bus.in_ready, 0);
      if (k == 9) check_eq("t4s_issue_id0", bus.issue_id[0], 6'd8);
      tick();
    end

    // Two memory ops in one pair; rt = r0 is ready despite a busy position.
    bus.in_valid = 1'b1;
    set_slot(0, 6'd9, 5'd2, 5'd0, 5'd12, 1'b1, 3'd2, 1'b1, 1'b0);
    set_slot(1, 6'd10, 5'd3, 5'd0, 5'd13, 1'b1, 3'd2, 1'b1, 1'b0);
    #1 check_eq("t5_accept_ready", bus.in_ready, 1);
    tick(); clear_inputs(); bus.sb_pos[1] = 8'hFF; bus.sb_pos[3] = 8'hFF; #1;
    check_eq("t5_c0_issue_valid", bus.issue_valid, 2'b01);
    check_eq("t5_c0_issue_id0", bus.issue_id[0], 6'd9);
    check_eq("t5_c0_write_pos0", bus.sb_write_pos[0], 8'h04);
    tick(); clear_inputs(); bus.sb_pos[1] = 8'hFF; bus.sb_pos[3] = 8'hFF; #1;
    check_eq("t5_c1_issue_valid", bus.issue_valid, 2'b01);
    check_eq("t5_c1_issue_id0", bus.issue_id[0], 6'd10);
    check_eq("t5_c1_write_addr0", bus.sb_write_addr[0], 5'd13);
    tick(); clear_inputs();
    repeat (8) tick();

    // Flush (with stall) while BUSY and half a pair left in the buffer.
    bus.in_valid = 1'b1;
    set_slot(0, 6'd11, 5'd2, 5'd3, 5'd0, 1'b0, 3'd1, 1'b0, 1'b1);
    set_slot(1, 6'd12, 5'd4, 5'd5, 5'd0, 1'b0, 3'd1, 1'b0, 1'b1);
    tick(); clear_inputs(); #1;
    check_eq("t6_c0_issue_valid", bus.issue_valid, 2'b01);
    check_eq("t6_c0_issue_id0", bus.issue_id[0], 6'd11);
    check_eq("t6_c0_in_ready", bus.in_ready, 0);
    tick(); clear_inputs(); stall = 1'b1; flush = 1'b1; #1;
    check_eq("t6_flush_issue_valid", bus.issue_valid, 0);
    tick(); clear_inputs();
    bus.in_valid = 1'b1;
    set_slot(0, 6'd13, 5'd6, 5'd7, 5'd0, 1'b0, 3'd1, 1'b0, 1'b1);
    #1;
    check_eq("t6_after_in_ready", bus.in_ready, 1);
    check_eq("t6_after_issue_valid", bus.issue_valid, 0);
    tick(); clear_inputs(); #1;
    check_eq("t6_new_mdu_issue", bus.issue_valid, 2'b01);
    check_eq("t6_new_mdu_id0", bus.issue_id[0], 6'd13);
    tick();

`ifdef ISSUE_PERF_CNT_EN
    check_eq("perf_dual", perf_dual, 1);
    check_eq("perf_hazard", perf_hazard, 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Dual-issue in-order issue controller between the decode queue and the execute pipes.
- Buffers one decoded instruction pair and reads the register scoreboard for all four source operands.
- Each cycle it decides which of slot 0 / slot 1 may issue, and writes issued destinations back into the scoreboard.
- Sequences the shared multi-cycle MDU (mult/div) unit with a busy FSM.

Parameters:
POS_W, 8, width of the scoreboard position field (shift vector; bit k = result lands in k cycles)
FWD_SLACK, 1, operand counts as ready when (pos >> FWD_SLACK) == 0
MDU_LAT, 6, cycles the MDU stays busy after an MDU issue
ID_W, 6, instruction tag width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  1  global pipeline stall
flush  in  1  pipeline flush
in_valid  in  1  decode offers a pair
in_ready  out  1  scheduler accepts the pair
in_slot_v  in  2  per-slot instruction present
in_id  in  2xID_W  per-slot tag
in_rs, in_rt, in_rd  in  2x5 each  source/dest register numbers
in_wr  in  2  writes in_rd
in_lat  in  2x3  result latency in cycles (1..7)
in_mem, in_mdu  in  2 each  memory op / MDU op flags
sb_read_addr  out  4x5  {s1.rt, s1.rs, s0.rt, s0.rs}
sb_pos  in  4xPOS_W  scoreboard position for each read address (same cycle)
sb_write_ena  out  2  scoreboard write enables
sb_write_addr  out  2x5  scoreboard write addresses
sb_write_pos  out  2xPOS_W  written position = 1 << lat
issue_valid  out  2  slot issues this cycle
issue_id  out  2xID_W  tag of the issued slot (slot 1 output valid only if slot 0 issues)

Behaviour:
- Buffer: two entries, B0 (older) and B1.
- in_ready = 1 when both entries are empty, or when every valid entry issues this cycle and stall = 0.
- Handshake: in_valid && in_ready loads B0/B1 from slot 0/1 at the clock edge. If only in_slot_v[1] is set, the instruction is compacted into B0.
- Operand ready: register 0 is always ready; otherwise ready when (sb_pos >> FWD_SLACK) == 0.
- B0 issues when all of the following hold:
  - B0 is valid and both its operands are ready;
  - not (in_mdu && FSM == BUSY);
  - stall = 0 and flush = 0.
- B1 issues only when all of the following hold:
  - B0 issues and B1 is valid with both operands ready;
  - no intra-pair RAW: B0.wr && B0.rd != 0 && B0.rd is in {B1.rs, B1.rt};
  - no intra-pair WAW on the same rd;
  - not both in_mem;
  - not both in_mdu, and B1 is not in_mdu while BUSY.
- Partial issue: when only B0 issues, B1 shifts into B0 at the edge and B1 becomes empty. No new pair is accepted that cycle.
- Scoreboard write: an issuing slot with wr = 1 and rd != 0 drives sb_write_ena = 1 and sb_write_pos = 1 << lat (combinational, same cycle as issue_valid). Writes never occur while stalled.
- MDU FSM: IDLE -> BUSY when an MDU op issues; the counter loads MDU_LAT-1. In BUSY the counter decrements each non-stalled cycle, and the FSM returns to IDLE when the counter = 0 is seen. Stall freezes the counter.
- stall = 1: buffer, FSM and counter hold; issue_valid = 0; in_ready = 0.
- flush = 1 (priority over stall): buffer cleared, FSM -> IDLE, counter = 0, issue_valid = 0 that cycle.
- Reset values: buffer empty, FSM IDLE, counter 0, in_ready = 1, issue_valid = 0, sb_write_ena = 0. A reset mid-MDU aborts the MDU busy state.

Optional Feature:
ISSUE_PERF_CNT_EN:
- Defined: adds outputs perf_dual[31:0] and perf_hazard[31:0].
  - perf_dual increments on every cycle in which both slots issue.
  - perf_hazard increments on every non-stalled, non-flushed cycle in which B0 is valid but does not issue.
  - Both counters wrap at 2^32, clear on rst, and are not affected by flush.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- Independent pair (s0 add r1 <- r2,r3; s1 add r4 <- r5,r6), all sb_pos = 0 -> issue_valid = 2'b11 the same cycle; sb_write_ena = 11, addr {4,1}, pos = 1 << lat; in_ready = 1.
- Intra-pair RAW (s0 rd = r1, s1 rs = r1) -> cycle 0: issue_valid = 01, in_ready = 0; cycle 1: s1 issues from B0 (issue_valid = 01), in_ready = 1.
- Scoreboard hazard: sb_pos for s0.rs = 8'b0000_0100 and decrementing each cycle -> no issue while pos >> 1 != 0; B0 issues in the cycle pos = 1; perf_hazard (if enabled) = 2.
- MDU busy: div issues, then another div offered 2 cycles later with MDU_LAT = 6 -> second div issues exactly 6 cycles after the first. A stall asserted for 3 cycles in between delays it to 9 cycles.
- Two load ops in one pair -> issue_valid = 01 then 01 on the following cycle.
- Flush while BUSY with a partially issued pair -> next cycle buffer empty, in_ready = 1, a new MDU op issues immediately; stall and flush asserted together -> flush wins.
